// File: rtl/alu_issue.sv
// Command FIFO in front of an external combinational ALU, plus a registered
// result stage with valid/ready. Optional signed-overflow flag: ALU_ISSUE_OVF_EN.
module alu_issue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_c,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic [1:0]               alu_c,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    input  logic [W-1:0]             alu_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_y,
    output logic [1:0]               out_c,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          wr_cmd;
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty, full, push, pop;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_y_q, out_y_d;
    logic [1:0]    out_c_q, out_c_d;
    logic          out_zero_q, out_zero_d;
    logic          out_neg_q, out_neg_d;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && (!out_valid_q || out_ready);

    assign wr_cmd = '{c: in_c, a: in_a, b: in_b};

    // Head entry feeds the ALU; forced to zero when nothing is queued.
    assign head  = empty ? cmd_t'('0) : mem_q[rd_ptr_q];
    assign alu_c = head.c;
    assign alu_a = head.a;
    assign alu_b = head.b;

    // Storage carries no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_cmd;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture on pop; otherwise a handshake with nothing queued drains the slot.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_c_d     = out_c_q;
        out_zero_d  = out_zero_q;
        out_neg_d   = out_neg_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_y_d     = alu_y;
            out_c_d     = head.c;
            out_zero_d  = (alu_y == '0);
            out_neg_d   = alu_y[W-1];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_c_q     <= '0;
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_c_q     <= out_c_d;
            out_zero_q  <= out_zero_d;
            out_neg_q   <= out_neg_d;
        end
    end

`ifdef ALU_ISSUE_OVF_EN
    logic out_ovf_q, ovf_calc;

    always_comb begin
        ovf_calc = 1'b0;
        case (head.c)
            2'b00:   ovf_calc = (head.a[W-1] == head.b[W-1]) && (alu_y[W-1] != head.a[W-1]);
            2'b01:   ovf_calc = (head.a[W-1] != head.b[W-1]) && (alu_y[W-1] != head.a[W-1]);
            default: ovf_calc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   out_ovf_q <= 1'b0;
        else if (pop) out_ovf_q <= ovf_calc;
    end

    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_c     = out_c_q;
    assign out_zero  = out_zero_q;
    assign out_neg   = out_neg_q;
    assign count     = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; supplies the combinational ALU it wraps.
module tb_alu_issue;
    localparam int DEPTH = 4;
`ifdef ALU_ISSUE_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_ready;
    logic [1:0]  in_c, alu_c, out_c;
    logic [31:0] in_a, in_b, alu_a, alu_b, alu_y, out_y;
    logic        out_valid, out_zero, out_neg, out_ovf;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    alu_issue #(.DEPTH(DEPTH), .W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_c(in_c), .in_a(in_a), .in_b(in_b),
        .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_c(out_c),
        .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_y = alu_ref(alu_c, alu_a, alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; in_c = c; in_a = a; in_b = b;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({out_valid, count, in_ready, out_y, out_zero, out_neg, out_ovf} !== {1'b0, 3'd0, 1'b1, 32'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state: valid=%b count=%0d ready=%b y=%h flags=%b%b%b, need 0/0/1/0/000",
                     out_valid, count, in_ready, out_y, out_zero, out_neg, out_ovf);
        end
        n_vec++;
        if ({alu_c, alu_a, alu_b} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_alu_drive: c=%b a=%h b=%h, need all 0", alu_c, alu_a, alu_b);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 32'd5, 32'd7);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        n_vec++;
        if ({out_valid, count, alu_a, alu_b} !== {1'b0, 3'd1, 32'd5, 32'd7}) begin
            n_err++;
            $display("FAIL single_edge1: valid=%b count=%0d a=%0d b=%0d, need 0/1/5/7", out_valid, count, alu_a, alu_b);
        end
        tick();
        n_vec++;
        if ({out_valid, out_y, out_c, out_zero, out_neg, out_ovf} !== {1'b1, 32'd12, 2'b00, 3'b000}) begin
            n_err++;
            $display("FAIL single_result: valid=%b y=%0d c=%b flags=%b%b%b, need 1/12/00/000",
                     out_valid, out_y, out_c, out_zero, out_neg, out_ovf);
        end
        tick();
        n_vec++;
        if ({out_valid, out_y} !== {1'b0, 32'd12}) begin
            n_err++;
            $display("FAIL single_drain: valid=%b y=%0d, need 0/12", out_valid, out_y);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_y [5];
        exp_y[0] = 32'd3; exp_y[1] = 32'd7; exp_y[2] = 32'h0F; exp_y[3] = 32'hFF; exp_y[4] = 32'd300;
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd1, 32'd2);          tick();
        drive(1'b1, 2'b01, 32'd10, 32'd3);         tick();
        drive(1'b1, 2'b10, 32'hFF, 32'h0F);        tick();
        drive(1'b1, 2'b11, 32'hAA, 32'h55);        tick();
        drive(1'b1, 2'b00, 32'd100, 32'd200);      tick();
        drive(1'b1, 2'b00, 32'd9, 32'd9);
        n_vec++;
        if ({in_ready, count, out_valid, out_y, out_c} !== {1'b0, 3'd4, 1'b1, 32'd3, 2'b00}) begin
            n_err++;
            $display("FAIL bp_full: ready=%b count=%0d valid=%b y=%0d c=%b, need 0/4/1/3/00",
                     in_ready, count, out_valid, out_y, out_c);
        end
        n_vec++;
        if ({alu_c, alu_a} !== {2'b01, 32'd10}) begin
            n_err++;
            $display("FAIL bp_head: c=%b a=%0d, need 01/10", alu_c, alu_a);
        end
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        n_vec++;
        if ({count, out_y} !== {3'd4, 32'd3}) begin
            n_err++;
            $display("FAIL bp_push_full_ignored: count=%0d y=%0d, need 4/3", count, out_y);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            n_vec++;
            if ({out_valid, out_y, out_zero, out_neg} !== {1'b1, exp_y[k], 2'b00}) begin
                n_err++;
                $display("FAIL bp_order[%0d]: valid=%b y=%h z=%b n=%b, need 1/%h/0/0",
                         k, out_valid, out_y, out_zero, out_neg, exp_y[k]);
            end
        end
        tick();
        n_vec++;
        if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL bp_empty: valid=%b count=%0d ready=%b, need 0/0/1", out_valid, count, in_ready);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_q [$];
        logic [31:0] e;
        int got = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 23; k++) begin
            if (k < 20) begin
                case (k % 4)
                    0: begin drive(1'b1, 2'b00, 32'(k), 32'(3 * k));     exp_q.push_back(32'(4 * k)); end
                    1: begin drive(1'b1, 2'b01, 32'd3, 32'd5);           exp_q.push_back(32'hFFFF_FFFE); end
                    2: begin drive(1'b1, 2'b10, 32'hF0F0, 32'h0FF0);     exp_q.push_back(32'h0000_00F0); end
                    default: begin drive(1'b1, 2'b11, 32'(k * 'h111), 32'(k * 'h111)); exp_q.push_back(32'd0); end
                endcase
            end else begin
                drive(1'b0, 2'b00, 32'd0, 32'd0);
            end
            tick();
            n_vec++;
            if (count > 3'd1 || !in_ready) begin
                n_err++;
                $display("FAIL stream_occupancy[%0d]: count=%0d ready=%b, need <=1/1", k, count, in_ready);
            end
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                got++;
                n_vec++;
                if ({out_y, out_zero, out_neg} !== {e, (e == 32'd0), e[31]}) begin
                    n_err++;
                    $display("FAIL stream_result[%0d]: y=%h z=%b n=%b, need %h/%b/%b",
                             got - 1, out_y, out_zero, out_neg, e, (e == 32'd0), e[31]);
                end
            end
        end
        n_vec++;
        if (got != 20 || out_valid) begin
            n_err++;
            $display("FAIL stream_count: results=%0d valid=%b, need 20/0", got, out_valid);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h7FFF_FFFF, 32'd1); tick();
        drive(1'b1, 2'b01, 32'h8000_0000, 32'd1); tick();
        n_vec++;
        if ({out_y, out_neg, out_ovf} !== {32'h8000_0000, 1'b1, OVF}) begin
            n_err++;
            $display("FAIL ovf_add: y=%h neg=%b ovf=%b, need 80000000/1/%b", out_y, out_neg, out_ovf, OVF);
        end
        drive(1'b1, 2'b00, 32'h7FFF_FFFE, 32'd1); tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        n_vec++;
        if ({out_y, out_neg, out_ovf} !== {32'h7FFF_FFFF, 1'b0, OVF}) begin
            n_err++;
            $display("FAIL ovf_sub: y=%h neg=%b ovf=%b, need 7fffffff/0/%b", out_y, out_neg, out_ovf, OVF);
        end
        tick();
        n_vec++;
        if ({out_y, out_ovf} !== {32'h7FFF_FFFF, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_none: y=%h ovf=%b, need 7fffffff/0", out_y, out_ovf);
        end
        tick();
    endtask

    task automatic test_hold();
        logic [31:0] exp_q [$];
        logic [31:0] py, pa, pb, e;
        logic [1:0]  pc, pcmd;
        logic        pv, pr, pushed;
        int idx = 0;
        int got = 0;
        for (int cyc = 0; cyc < 400 && got < 3 * DEPTH; cyc++) begin
            if (idx < 3 * DEPTH)
                drive(1'b1, 2'(idx % 4), 32'(idx) * 32'h1100_1001 + 32'd7, 32'(idx) + 32'd1);
            else
                drive(1'b0, 2'b00, 32'd0, 32'd0);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            pv = out_valid; pr = out_ready; py = out_y; pc = out_c;
            pushed = in_valid && in_ready; pcmd = in_c; pa = in_a; pb = in_b;
            tick();
            if (pushed) begin
                exp_q.push_back(alu_ref(pcmd, pa, pb));
                idx++;
            end
            if (pv && !pr) begin
                n_vec++;
                if ({out_valid, out_y, out_c} !== {1'b1, py, pc}) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%b y=%h c=%b, need 1/%h/%b", out_valid, out_y, out_c, py, pc);
                end
            end
            if (pv && pr) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : ~py;
                got++;
                n_vec++;
                if (py !== e) begin
                    n_err++;
                    $display("FAIL hold_result[%0d]: y=%h, need %h", got - 1, py, e);
                end
            end
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        out_ready = 1'b1;
        tick(); tick();
        n_vec++;
        if (got != 3 * DEPTH || exp_q.size() != 0 || out_valid || count != 3'd0) begin
            n_err++;
            $display("FAIL hold_total: consumed=%0d left=%0d valid=%b count=%0d, need %0d/0/0/0",
                     got, exp_q.size(), out_valid, count, 3 * DEPTH);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd1, 32'd1); tick();
        drive(1'b1, 2'b01, 32'd5, 32'd9); tick();
        drive(1'b1, 2'b00, 32'd6, 32'd6); tick();
        drive(1'b1, 2'b11, 32'd4, 32'd2); tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        n_vec++;
        if ({out_valid, count, in_ready} !== {1'b1, 3'd3, 1'b1}) begin
            n_err++;
            $display("FAIL mid_setup: valid=%b count=%0d ready=%b, need 1/3/1", out_valid, count, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, count, in_ready, out_y, out_c, out_zero, out_neg, out_ovf} !==
            {1'b0, 3'd0, 1'b1, 32'd0, 2'b00, 3'b000}) begin
            n_err++;
            $display("FAIL mid_async_reset: valid=%b count=%0d ready=%b y=%h c=%b flags=%b%b%b, need 0/0/1/0/00/000",
                     out_valid, count, in_ready, out_y, out_c, out_zero, out_neg, out_ovf);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        n_vec++;
        if ({out_valid, count, alu_a} !== {1'b0, 3'd0, 32'd0}) begin
            n_err++;
            $display("FAIL mid_discarded: valid=%b count=%0d a=%h, need 0/0/0", out_valid, count, alu_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        #3;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_overflow();
        test_hold();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Command-buffering and result-capture stage that wraps the 32-bit combinational ALU (op 00 add, 01 sub, 10 and, 11 xor).
- Upstream, it queues {op, a, b} commands through a valid/ready handshake in a DEPTH-entry FIFO and drives the head entry onto the ALU operand inputs.
- Downstream, it registers the ALU result with zero/negative flags behind a second valid/ready handshake, sustaining one operation per cycle.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- W, 32, operand/result width; fixed at 32 to match the ALU

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept (= not full)
- in_c  in  2  ALU op code
- in_a  in  W  operand a
- in_b  in  W  operand b
- alu_c  out  2  op to ALU (head entry)
- alu_a  out  W  operand a to ALU
- alu_b  out  W  operand b to ALU
- alu_y  in  W  combinational result from ALU
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts result
- out_y  out  W  registered result
- out_c  out  2  op code that produced out_y
- out_zero  out  1  out_y == 0
- out_neg  out  1  out_y[W-1]
- out_ovf  out  1  signed overflow (see Configuration)
- count  out  log2(DEPTH)+1  FIFO occupancy

Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- **Push:** `in_valid && in_ready` writes {in_c, in_a, in_b} at wr_ptr. wr_ptr wraps modulo DEPTH.
- **ALU drive:**
  - alu_c/alu_a/alu_b come combinationally from the FIFO storage entry at rd_ptr.
  - When the FIFO is empty, all three are driven 0.
- **Pop/capture:**
  - Condition: `pop = (count != 0) && (!out_valid || out_ready)`.
  - On pop, at the clock edge:
    - out_y <= alu_y; out_c <= alu_c
    - out_zero <= (alu_y == 0); out_neg <= alu_y[W-1]; out_ovf per Configuration
    - out_valid <= 1; rd_ptr advances, wrapping modulo DEPTH.
- **Drain:** `out_ready && out_valid && count == 0` clears out_valid. out_y and the flags hold their last values.
- **Output stability:** while `out_valid && !out_ready`, out_y, out_c and all flags are held stable.
- **Simultaneous push and pop:** count is unchanged. This is legal at any non-full occupancy.
- **Full:**
  - in_ready = 0 when count == DEPTH, even if a pop happens in the same cycle; there is no same-cycle pass-through.
  - A push attempted while full is ignored.
- **Empty:** no pop occurs. out_valid behaves as described under Drain.
- **Arithmetic:** result width is W. The carry-out is not reported; add/sub wrap modulo 2^W.

## Timing
- **Reset** (asynchronous, any time, including mid-stream): pointers, count, out_valid, out_y, out_c and all flags go to 0. in_ready = 1 during and after reset. Queued commands are discarded.
- **Latency:** a command pushed at edge N is at the head after N. The earliest capture is at edge N+1, with out_valid = 1 after N+1. Input-to-output latency is 2 cycles minimum.
- **Throughput:** 1 result per cycle while `out_ready = 1` and the FIFO is non-empty.
- **Combinational paths:** the ALU is a single-cycle combinational path from alu_a/alu_b/alu_c to alu_y. No other combinational in→out path exists except in_ready from count.

## Configuration
Macro `ALU_ISSUE_OVF_EN`.
- **Defined:** out_ovf is computed at capture from the head operands and alu_y:
  - add (00): `a[W-1] == b[W-1] && y[W-1] != a[W-1]`
  - sub (01): `a[W-1] != b[W-1] && y[W-1] != a[W-1]`
  - and/xor: 0
- **Undefined:** the out_ovf port is still present and tied to 0. No overflow logic is synthesized.

## Test plan
- **Reset values:** assert rst_n = 0 mid-stream with 3 entries queued and out_valid = 1 -> out_valid = 0, count = 0, in_ready = 1, out_y = 0, all flags 0, immediately (asynchronously).
- **Single command latency:** push add a = 5, b = 7 with out_ready = 1 -> out_valid rises 2 edges later with out_y = 12, out_c = 00, out_zero = 0, out_neg = 0.
- **Back-pressure and full:** hold out_ready = 0, push 5 commands with DEPTH = 4:
  - 1st command captured in the output register; next 4 fill the FIFO.
  - in_ready = 0, count = 4; the 6th push is ignored.
  - Release out_ready -> results emerge in order, 1 per cycle.
- **Streaming:** continuous push with out_ready = 1 for 20 cycles, cycling through all four ops -> count stays ≤1 and in_ready stays 1. Results match:
  - sub 3−5 = 0xFFFFFFFE (neg = 1)
  - and 0xF0F0&0x0FF0 = 0x00F0
  - xor x^x = 0 (zero = 1)
- **Overflow, ALU_ISSUE_OVF_EN defined:**
  - add 0x7FFFFFFF + 1 -> out_y = 0x80000000, ovf = 1, neg = 1.
  - sub 0x80000000 − 1 -> out_y = 0x7FFFFFFF, ovf = 1.
  - Without the macro, ovf = 0 for both.
- **Output hold:** out_ready toggled randomly with pointer wrap over 3×DEPTH entries -> no result lost or duplicated, and out_y is stable while stalled.
